// File: rtl/logic_op_sequencer_pkg.sv
// Shared types and constants for the logic-unit operand/opcode sequencer.
// The opcode values match the logic unit's own decode of opcode[1:0].
package logic_op_sequencer_pkg;

  localparam int OPW_DEF  = 5;
  localparam int RESW_DEF = 9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  localparam logic [1:0] OP_OR   = 2'd0;
  localparam logic [1:0] OP_AND  = 2'd1;
  localparam logic [1:0] OP_NAND = 2'd2;
  localparam logic [1:0] OP_NOR  = 2'd3;

  // Index of the lowest set bit. Only called with a non-zero mask.
  function automatic logic [1:0] lowest_idx(input logic [3:0] m);
    if (m[0])      return OP_OR;
    else if (m[1]) return OP_AND;
    else if (m[2]) return OP_NAND;
    else           return OP_NOR;
  endfunction

endpackage

// File: rtl/logic_op_sequencer_if.sv
// Result stream port: show-ahead {opcode,result} entries on a valid/ready handshake.
interface logic_op_sequencer_if #(parameter int RESW = 9);
  logic            out_valid;
  logic            out_ready;
  logic [1:0]      out_opcode;
  logic [RESW-1:0] out_data;

  modport master (output out_valid, out_opcode, out_data, input out_ready);
  modport slave  (input out_valid, out_opcode, out_data, output out_ready);
endinterface

// File: rtl/logic_op_sequencer_res_fifo.sv
// Show-ahead result FIFO; push and pop may coincide at any fill level, including full.
module logic_res_fifo #(
  parameter int W     = 11,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only taken when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/logic_op_sequencer.sv
// Drives one operand pair through each enabled logic-unit opcode in ascending
// order and streams the captured {opcode,result} pairs out through a FIFO.
module logic_op_sequencer
  import logic_op_sequencer_pkg::*;
#(
  parameter int OPW        = OPW_DEF,
  parameter int RESW       = RESW_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [OPW-1:0]         op_a,
  input  logic [OPW-1:0]         op_b,
  input  logic [3:0]             op_mask,
  output logic                   busy,
  output logic [OPW-1:0]         drv_in1,
  output logic [OPW-1:0]         drv_in2,
  output logic [2:0]             drv_opcode,
  input  logic [RESW-1:0]        res_logic,
  output logic                   done,
  logic_op_sequencer_if.master   rsp
);

  state_t         state, state_nx;
  logic [OPW-1:0] a_q, b_q;
  logic [3:0]     pend, pend_left;
  logic           accept, issue_go, push, pop, done_nx, finish;
  logic           fifo_full, fifo_empty;
  logic [RESW+1:0] fifo_dout;

  assign pend_left = pend & ~(4'b0001 << drv_opcode[1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (op_mask == 4'b0) ? DRAIN : ISSUE;
      ISSUE:   if (!fifo_full) state_nx = CAPTURE;
      CAPTURE: state_nx = (pend_left != 4'b0) ? ISSUE : DRAIN;
      DRAIN:   if (done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // done is registered, so DRAIN is held through the pulse and busy drops after it.
  always_comb begin
    accept   = (state == IDLE) && start;
    issue_go = (state == ISSUE) && !fifo_full;
    push     = (state == CAPTURE);
    done_nx  = (state == DRAIN) && fifo_empty && !done;
    finish   = (state == DRAIN) && done;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      pend       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      drv_in1    <= '0;
      drv_in2    <= '0;
      drv_opcode <= '0;
    end else begin
      done <= done_nx;
      if (accept) begin
        a_q  <= op_a;
        b_q  <= op_b;
        pend <= op_mask;
        busy <= 1'b1;
      end
      if (issue_go) begin
        drv_in1    <= a_q;
        drv_in2    <= b_q;
        drv_opcode <= {1'b0, lowest_idx(pend)};
      end
      if (push)   pend <= pend_left;
      if (finish) busy <= 1'b0;
    end
  end

  assign pop = rsp.out_valid && rsp.out_ready;

  logic_res_fifo #(.W(RESW + 2), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   ({drv_opcode[1:0], res_logic}),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rsp.out_valid  = !fifo_empty;
  assign rsp.out_opcode = fifo_dout[RESW+1:RESW];
  assign rsp.out_data   = fifo_dout[RESW-1:0];

endmodule
